// File: rtl/prefetch_pkg.sv
// Shared types and helpers for the prefetch scheduler and its queue.
package prefetch_pkg;

    // Default log2 of the cache line size in bytes.
    localparam int unsigned LOGLINE = 6;

    // Widest address the line helper accepts; callers zero-extend into it.
    localparam int unsigned ADDR_W_MAX = 128;

    // Output slot state: empty, holding a demand, or holding a prefetch.
    typedef enum logic [1:0] {
        SLOT_IDLE    = 2'd0,
        SLOT_HOLD_DM = 2'd1,
        SLOT_HOLD_PF = 2'd2
    } slot_state_e;

    // Line address of a byte address: strips the in-line offset bits.
    function automatic logic [ADDR_W_MAX-1:0] line_addr(
        input logic [ADDR_W_MAX-1:0] addr,
        input int unsigned           logline
    );
        return addr >> logline;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch candidate queue with per-entry valid bits and a line-match search port.
module prefetch_fifo #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned QDEPTH  = 8,
    parameter int unsigned LOGLINE = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_addr_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    input  logic [WIDTH-1:0] cmp_addr_i,
    output logic             match_o
);
    import prefetch_pkg::*;

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [WIDTH-1:0]  mem_q [QDEPTH];
    logic [WIDTH-1:0]  mem_d [QDEPTH];
    logic [QDEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(QDEPTH));

    // Search every valid entry for the candidate's line.
    always_comb begin
        match_o = 1'b0;
        for (int i = 0; i < int'(QDEPTH); i++) begin
            if (vld_q[i] &&
                (line_addr(ADDR_W_MAX'(mem_q[i]), LOGLINE) ==
                 line_addr(ADDR_W_MAX'(cmp_addr_i), LOGLINE))) begin
                match_o = 1'b1;
            end
        end
    end

    // Next queue state: pop frees the head, push fills the tail, flush clears all.
    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop_i) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = PW'(rd_ptr_q + PW'(1));
        end
        if (push_i && !flush_i) begin
            mem_d[wr_ptr_q] = push_addr_i;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = PW'(wr_ptr_q + PW'(1));
        end
        case ({push_i && !flush_i, pop_i})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            vld_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/prefetch_scheduler.sv
// Arbitrates demand misses and queued prefetches into one registered lower-level slot.
module prefetch_scheduler #(
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned QDEPTH       = 8,
    parameter int unsigned MSHR_COUNT   = 16,
    parameter int unsigned PF_THRESHOLD = 12,
    parameter int unsigned LOGLINE      = prefetch_pkg::LOGLINE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dm_valid_i,
    input  logic [WIDTH-1:0]                  dm_address_i,
    output logic                              dm_ready_o,
    input  logic                              pf_valid_i,
    input  logic [WIDTH-1:0]                  pf_address_i,
    input  logic                              flush_i,
    input  logic                              mshr_release_i,
    input  logic                              lo_ready_i,
    output logic                              lo_valid_o,
    output logic [WIDTH-1:0]                  lo_address_o,
    output logic                              lo_is_prefetch_o,
    output logic [$clog2(MSHR_COUNT+1)-1:0]   inflight_o,
    output logic [15:0]                       pf_drop_count_o
);
    import prefetch_pkg::*;

    localparam int unsigned IW = $clog2(MSHR_COUNT + 1);

    slot_state_e      state_q, state_d;
    logic             lo_valid_q, lo_valid_d;
    logic [WIDTH-1:0] lo_address_q, lo_address_d;
    logic             lo_is_pf_q, lo_is_pf_d;
    logic [IW-1:0]    inflight_q, inflight_d;
    logic [15:0]      drop_q, drop_d;

    logic             handshake;
    logic             slot_free;
    logic             dm_accept;
    logic             pf_pop;
    logic             pf_push;
    logic             pf_drop;
    logic             pf_dup;
    logic             q_match;
    logic             q_empty;
    logic             q_full;
    logic [WIDTH-1:0] q_head;

    assign handshake  = lo_valid_q && lo_ready_i;
    assign slot_free  = (state_q == SLOT_IDLE) || handshake;
    assign dm_ready_o = slot_free && (inflight_q < IW'(MSHR_COUNT));
    assign dm_accept  = dm_valid_i && dm_ready_o;
    assign pf_pop     = slot_free && !dm_accept && !q_empty &&
                        (inflight_q < IW'(PF_THRESHOLD));

    // A candidate is redundant if its line is already queued or sitting in the slot.
    assign pf_dup  = q_match ||
                     (lo_valid_q &&
                      (line_addr(ADDR_W_MAX'(lo_address_q), LOGLINE) ==
                       line_addr(ADDR_W_MAX'(pf_address_i), LOGLINE)));
    assign pf_push = pf_valid_i && !flush_i && !pf_dup && (!q_full || pf_pop);
    assign pf_drop = pf_valid_i && !flush_i && !pf_push;

    prefetch_fifo #(
        .WIDTH   (WIDTH),
        .QDEPTH  (QDEPTH),
        .LOGLINE (LOGLINE)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pf_push),
        .push_addr_i (pf_address_i),
        .pop_i       (pf_pop),
        .flush_i     (flush_i),
        .head_o      (q_head),
        .empty_o     (q_empty),
        .full_o      (q_full),
        .cmp_addr_i  (pf_address_i),
        .match_o     (q_match)
    );

    // Slot FSM next state: demand beats prefetch, otherwise drain or hold.
    always_comb begin
        state_d      = state_q;
        lo_address_d = lo_address_q;
        if (dm_accept) begin
            state_d      = SLOT_HOLD_DM;
            lo_address_d = dm_address_i;
        end else if (pf_pop) begin
            state_d      = SLOT_HOLD_PF;
            lo_address_d = q_head;
        end else if (handshake) begin
            state_d      = SLOT_IDLE;
        end
        lo_valid_d = (state_d != SLOT_IDLE);
        lo_is_pf_d = (state_d == SLOT_HOLD_PF);
    end

    // Outstanding-request and drop counters, both saturating.
    always_comb begin
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (handshake && !mshr_release_i) begin
            if (inflight_q < IW'(MSHR_COUNT)) begin
                inflight_d = IW'(inflight_q + IW'(1));
            end
        end else if (mshr_release_i && !handshake) begin
            if (inflight_q != '0) begin
                inflight_d = IW'(inflight_q - IW'(1));
            end
        end
        if (pf_drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // State register; reset abandons any held request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SLOT_IDLE;
            lo_valid_q   <= 1'b0;
            lo_address_q <= '0;
            lo_is_pf_q   <= 1'b0;
            inflight_q   <= '0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            lo_valid_q   <= lo_valid_d;
            lo_address_q <= lo_address_d;
            lo_is_pf_q   <= lo_is_pf_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
        end
    end

    assign lo_valid_o       = lo_valid_q;
    assign lo_address_o     = lo_address_q;
    assign lo_is_prefetch_o = lo_is_pf_q;
    assign inflight_o       = inflight_q;
    assign pf_drop_count_o  = drop_q;

endmodule

// File: tb/tb_prefetch_scheduler.sv
// Directed self-checking bench for prefetch_scheduler with default parameters.
module tb_prefetch_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        dm_valid_i;
    logic [63:0] dm_address_i;
    logic        dm_ready_o;
    logic        pf_valid_i;
    logic [63:0] pf_address_i;
    logic        flush_i;
    logic        mshr_release_i;
    logic        lo_ready_i;
    logic        lo_valid_o;
    logic [63:0] lo_address_o;
    logic        lo_is_prefetch_o;
    logic [4:0]  inflight_o;
    logic [15:0] pf_drop_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prefetch_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .dm_valid_i       (dm_valid_i),
        .dm_address_i     (dm_address_i),
        .dm_ready_o       (dm_ready_o),
        .pf_valid_i       (pf_valid_i),
        .pf_address_i     (pf_address_i),
        .flush_i          (flush_i),
        .mshr_release_i   (mshr_release_i),
        .lo_ready_i       (lo_ready_i),
        .lo_valid_o       (lo_valid_o),
        .lo_address_o     (lo_address_o),
        .lo_is_prefetch_o (lo_is_prefetch_o),
        .inflight_o       (inflight_o),
        .pf_drop_count_o  (pf_drop_count_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        dm_valid_i     = 1'b0;
        dm_address_i   = '0;
        pf_valid_i     = 1'b0;
        pf_address_i   = '0;
        flush_i        = 1'b0;
        mshr_release_i = 1'b0;
        lo_ready_i     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_pf(input logic [63:0] addr);
        pf_valid_i   = 1'b1;
        pf_address_i = addr;
        tick();
        pf_valid_i   = 1'b0;
    endtask

    logic [63:0] exp_seq [8];

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_valid", 64'(lo_valid_o), 64'd0);
        check("rst_addr", lo_address_o, 64'd0);
        check("rst_is_pf", 64'(lo_is_prefetch_o), 64'd0);
        check("rst_inflight", 64'(inflight_o), 64'd0);
        check("rst_drop", 64'(pf_drop_count_o), 64'd0);
        check("rst_dm_ready", 64'(dm_ready_o), 64'd1);

        // Single demand through an idle slot
        lo_ready_i   = 1'b1;
        dm_valid_i   = 1'b1;
        dm_address_i = 64'h1000;
        #1;
        check("dm_ready_idle", 64'(dm_ready_o), 64'd1);
        tick();
        dm_valid_i = 1'b0;
        check("dm_valid", 64'(lo_valid_o), 64'd1);
        check("dm_addr", lo_address_o, 64'h1000);
        check("dm_is_pf", 64'(lo_is_prefetch_o), 64'd0);
        check("dm_inflight_pre", 64'(inflight_o), 64'd0);
        tick();
        check("dm_done_valid", 64'(lo_valid_o), 64'd0);
        check("dm_inflight", 64'(inflight_o), 64'd1);
        mshr_release_i = 1'b1;
        tick();
        mshr_release_i = 1'b0;
        check("release_inflight", 64'(inflight_o), 64'd0);
        mshr_release_i = 1'b1;
        tick();
        mshr_release_i = 1'b0;
        check("release_at_zero", 64'(inflight_o), 64'd0);

        // Demand beats a queued prefetch, prefetch follows without a bubble
        do_reset();
        dm_valid_i   = 1'b1;
        dm_address_i = 64'h5000;
        tick();
        dm_valid_i = 1'b0;
        push_pf(64'h2000);
        check("hold_stable_addr", lo_address_o, 64'h5000);
        lo_ready_i   = 1'b1;
        dm_valid_i   = 1'b1;
        dm_address_i = 64'h3000;
        tick();
        dm_valid_i = 1'b0;
        check("arb_dm_addr", lo_address_o, 64'h3000);
        check("arb_dm_is_pf", 64'(lo_is_prefetch_o), 64'd0);
        tick();
        check("arb_pf_valid", 64'(lo_valid_o), 64'd1);
        check("arb_pf_addr", lo_address_o, 64'h2000);
        check("arb_pf_is_pf", 64'(lo_is_prefetch_o), 64'd1);
        tick();
        check("arb_idle", 64'(lo_valid_o), 64'd0);
        check("arb_inflight", 64'(inflight_o), 64'd3);

        // Same-line duplicates against the queue and against the slot
        do_reset();
        lo_ready_i = 1'b1;
        push_pf(64'h4000);
        push_pf(64'h4010);
        check("dup_q_addr", lo_address_o, 64'h4000);
        check("dup_q_is_pf", 64'(lo_is_prefetch_o), 64'd1);
        check("dup_q_drop", 64'(pf_drop_count_o), 64'd1);
        push_pf(64'h4030);
        check("dup_slot_drop", 64'(pf_drop_count_o), 64'd2);
        check("dup_slot_idle", 64'(lo_valid_o), 64'd0);
        tick();
        check("dup_one_issue", 64'(lo_valid_o), 64'd0);
        check("dup_inflight", 64'(inflight_o), 64'd1);

        // Prefetches held at the in-flight threshold
        do_reset();
        lo_ready_i = 1'b1;
        dm_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            dm_address_i = 64'h100000 + 64'(i) * 64'h40;
            tick();
        end
        dm_valid_i = 1'b0;
        tick();
        check("thr_inflight", 64'(inflight_o), 64'd12);
        push_pf(64'h8000);
        tick();
        check("thr_held0", 64'(lo_valid_o), 64'd0);
        tick();
        check("thr_held1", 64'(lo_valid_o), 64'd0);
        mshr_release_i = 1'b1;
        tick();
        mshr_release_i = 1'b0;
        check("thr_rel_inflight", 64'(inflight_o), 64'd11);
        check("thr_rel_valid", 64'(lo_valid_o), 64'd0);
        tick();
        check("thr_issue_valid", 64'(lo_valid_o), 64'd1);
        check("thr_issue_addr", lo_address_o, 64'h8000);
        check("thr_issue_is_pf", 64'(lo_is_prefetch_o), 64'd1);
        tick();
        check("thr_after_inflight", 64'(inflight_o), 64'd12);

        // Full queue: drop, then accept on a simultaneous pop
        do_reset();
        push_pf(64'h10000);
        for (int i = 1; i <= 8; i++) begin
            push_pf(64'h10000 + 64'(i) * 64'h40);
        end
        check("full_slot_addr", lo_address_o, 64'h10000);
        check("full_no_drop", 64'(pf_drop_count_o), 64'd0);
        push_pf(64'h10000 + 64'd9 * 64'h40);
        check("full_drop", 64'(pf_drop_count_o), 64'd1);
        lo_ready_i = 1'b1;
        push_pf(64'h10000 + 64'd10 * 64'h40);
        check("full_pop_addr", lo_address_o, 64'h10040);
        check("full_pop_drop", 64'(pf_drop_count_o), 64'd1);
        for (int i = 0; i < 7; i++) begin
            exp_seq[i] = 64'h10000 + 64'(i + 2) * 64'h40;
        end
        exp_seq[7] = 64'h10000 + 64'd10 * 64'h40;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("drain_addr%0d", i), lo_address_o, exp_seq[i]);
            check($sformatf("drain_pf%0d", i), 64'(lo_is_prefetch_o), 64'd1);
        end
        tick();
        check("drain_empty", 64'(lo_valid_o), 64'd0);

        // Flush with a held prefetch and a same-cycle candidate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_pf(64'h20000 + 64'(i) * 64'h40);
        end
        check("flush_pre_addr", lo_address_o, 64'h20000);
        flush_i      = 1'b1;
        pf_valid_i   = 1'b1;
        pf_address_i = 64'h30000;
        tick();
        flush_i    = 1'b0;
        pf_valid_i = 1'b0;
        check("flush_hold_valid", 64'(lo_valid_o), 64'd1);
        check("flush_hold_addr", lo_address_o, 64'h20000);
        check("flush_hold_is_pf", 64'(lo_is_prefetch_o), 64'd1);
        check("flush_no_drop", 64'(pf_drop_count_o), 64'd0);
        lo_ready_i = 1'b1;
        tick();
        check("flush_done", 64'(lo_valid_o), 64'd0);
        tick();
        check("flush_empty", 64'(lo_valid_o), 64'd0);
        check("flush_inflight", 64'(inflight_o), 64'd1);

        // Reset abandons a held request
        lo_ready_i   = 1'b0;
        dm_valid_i   = 1'b1;
        dm_address_i = 64'h9000;
        tick();
        dm_valid_i = 1'b0;
        do_reset();
        tick();
        check("rst_abandon_valid", 64'(lo_valid_o), 64'd0);
        check("rst_abandon_addr", lo_address_o, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
